// File: rtl/nist_block_gen.sv
// nist_block_gen: serial test-bit generator emitting N_BLK 16-bit blocks, each with exactly k ones
module nist_block_gen #(
    parameter int          N_BLK    = 8,
    parameter logic [15:0] RST_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  ones_k,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic        rnd_out,
    output logic        bit_valid,
    output logic        blk_first,
    output logic        busy,
    output logic        done
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0]  state;
    logic [3:0]  pos;
    logic [4:0]  rem_ones;
    logic [4:0]  k_lat;
    logic [4:0]  k_in;
    logic [4:0]  k_nxt;
    logic [7:0]  blk_cnt;
    logic [15:0] lfsr;
    logic        run;
    logic        bit_now;
    logic        last_bit;
    logic        wrap;
    logic        fb;
    // Bit selection: out of ones gives 0, remaining slots all needed gives forced 1, else random
    always_comb begin
        run      = state == RUN;
        k_in     = ones_k > 5'd16 ? 5'd16 : ones_k;
        bit_now  = rem_ones == 5'd0 ? 1'b0 : rem_ones == 5'd16 - {1'b0, pos} ? 1'b1 : lfsr[0];
        last_bit = pos == 4'd15 && blk_cnt == 8'(N_BLK - 1);
        wrap     = run && pos == 4'd15 && !last_bit && !abort;
        k_nxt    = (!run && start) || wrap ? k_in : k_lat;
        fb       = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    end
    assign rnd_out   = run & bit_now;
    assign bit_valid = run;
    assign blk_first = run & (pos == 4'd0);
    assign busy      = run;
    // FSM, block position/ones bookkeeping and LFSR update
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            pos      <= 4'd0;
            rem_ones <= 5'd0;
            blk_cnt  <= 8'd0;
            k_lat    <= 5'd0;
            lfsr     <= RST_SEED;
            done     <= 1'b0;
        end else begin
            done  <= 1'b0;
            k_lat <= k_nxt;
            if (!run) begin
                if (start) begin
                    state    <= RUN;
                    pos      <= 4'd0;
                    blk_cnt  <= 8'd0;
                    rem_ones <= k_nxt;
                end else if (seed_load) begin
                    lfsr <= seed == 16'd0 ? RST_SEED : seed;
                end
            end else begin
                lfsr     <= {fb, lfsr[15:1]};
                pos      <= pos + 4'd1;
                rem_ones <= rem_ones - {4'd0, bit_now};
                if (abort) begin
                    state <= IDLE;
                end else if (last_bit) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else if (wrap) begin
                    rem_ones <= k_nxt;
                    blk_cnt  <= blk_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nist_block_gen.sv
// tb_nist_block_gen: randomized and directed checks of nist_block_gen against a block-level model
module tb_nist_block_gen;
    logic clk = 0, rstn = 0, start = 0, abort = 0, seed_load = 0;
    logic [4:0] ones_k = 0;
    logic [15:0] seed = 0;
    logic rnd_out, bit_valid, blk_first, busy, done;
    int n_chk = 0, n_pass = 0;
    logic [15:0] m_lfsr;
    logic got_q[$], exp_q[$], sav_q[$];
    int first_cnt, done_cnt, done_cyc, busy_cnt;

    nist_block_gen dut (.clk(clk), .rstn(rstn), .start(start), .abort(abort), .ones_k(ones_k),
        .seed_load(seed_load), .seed(seed), .rnd_out(rnd_out), .bit_valid(bit_valid),
        .blk_first(blk_first), .busy(busy), .done(done));

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic int clampk(input int k);
        return k > 16 ? 16 : k;
    endfunction

    // expected stream: block 0 uses k0, later blocks k1; each bit consumes one LFSR step
    task automatic gen_exp(input int nbits, input int k0, input int k1);
        int rem;
        logic b;
        rem = 0;
        exp_q.delete();
        for (int i = 0; i < nbits; i++) begin
            if (i % 16 == 0) rem = (i == 0) ? clampk(k0) : clampk(k1);
            if (rem == 0) b = 0;
            else if (rem == 16 - (i % 16)) b = 1;
            else b = m_lfsr[0];
            if (b) rem--;
            m_lfsr = lfsr_step(m_lfsr);
            exp_q.push_back(b);
        end
    endtask

    function automatic int blk_sum(input int blk);
        int s = 0;
        for (int i = blk * 16; i < blk * 16 + 16 && i < got_q.size(); i++) s += int'(got_q[i]);
        return s;
    endfunction

    function automatic int stream_diff();
        int d = 0;
        if (got_q.size() != exp_q.size()) return -1;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic load_seed(input logic [15:0] s);
        @(negedge clk);
        seed = s;
        seed_load = 1;
        @(negedge clk);
        seed_load = 0;
    endtask

    // one run: events are keyed on the 0-based index of the bit being emitted
    task automatic run(input logic [4:0] k, input int chg_at, input logic [4:0] k2,
                       input int abort_at, input int rst_at, input int restart_at,
                       input int sload_at, input bit sload_with_start);
        int idx;
        got_q.delete();
        first_cnt = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0;
        @(negedge clk);
        ones_k = k;
        start = 1;
        if (sload_with_start) begin seed = 16'hBEEF; seed_load = 1; end
        @(negedge clk);
        start = 0;
        seed_load = 0;
        for (int c = 1; c <= 200; c++) begin
            idx = -1;
            if (bit_valid) begin
                got_q.push_back(rnd_out);
                idx = got_q.size() - 1;
                if (blk_first) first_cnt++;
            end
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
            abort = 0; rstn = 1; start = 0; seed_load = 0;
            if (idx >= 0 && idx == abort_at) abort = 1;
            if (idx >= 0 && idx == rst_at) rstn = 0;
            if (idx >= 0 && idx == restart_at) start = 1;
            if (idx >= 0 && idx == sload_at) begin seed = 16'h5A5A; seed_load = 1; end
            if (idx >= 0 && idx == chg_at) ones_k = k2;
            @(negedge clk);
        end
        abort = 0; rstn = 1; start = 0; seed_load = 0;
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
        n_chk++; if (done !== 0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
        n_chk++; if ({bit_valid, rnd_out, blk_first} !== 3'b000)
            $display("FAIL reset_outs got %b want 000", {bit_valid, rnd_out, blk_first}); else n_pass++;
        rstn = 1;
        m_lfsr = 16'hACE1;
    endtask

    task automatic test_zero_ones();
        run(0, -1, 0, -1, -1, -1, -1, 0);
        gen_exp(128, 0, 0);
        n_chk++; if (got_q.size() != 128) $display("FAIL zero_nbits got %0d want 128", got_q.size()); else n_pass++;
        n_chk++; if (stream_diff() != 0) $display("FAIL zero_stream got %0d diffs want 0", stream_diff()); else n_pass++;
        n_chk++; if (first_cnt != 8) $display("FAIL zero_blk_first got %0d want 8", first_cnt); else n_pass++;
        n_chk++; if (done_cnt != 1) $display("FAIL zero_done_cnt got %0d want 1", done_cnt); else n_pass++;
        n_chk++; if (done_cyc != 129) $display("FAIL zero_done_cycle got %0d want 129", done_cyc); else n_pass++;
    endtask

    task automatic test_all_ones();
        int s = 0;
        run(16, -1, 0, -1, -1, -1, -1, 0);
        gen_exp(128, 16, 16);
        for (int b = 0; b < 8; b++) s += blk_sum(b);
        n_chk++; if (s != 128) $display("FAIL full_ones got %0d want 128", s); else n_pass++;
        n_chk++; if (busy_cnt != 128) $display("FAIL full_busy got %0d want 128", busy_cnt); else n_pass++;
        n_chk++; if (stream_diff() != 0) $display("FAIL full_stream got %0d diffs want 0", stream_diff()); else n_pass++;
    endtask

    task automatic test_seed_repeat();
        int bad = 0;
        load_seed(16'h1234);
        m_lfsr = 16'h1234;
        run(8, -1, 0, -1, -1, -1, -1, 0);
        gen_exp(128, 8, 8);
        for (int b = 0; b < 8; b++) if (blk_sum(b) != 8) bad++;
        n_chk++; if (bad != 0) $display("FAIL seed_blk_sums got %0d bad blocks want 0", bad); else n_pass++;
        n_chk++; if (stream_diff() != 0) $display("FAIL seed_stream got %0d diffs want 0", stream_diff()); else n_pass++;
        sav_q = got_q;
        load_seed(16'h1234);
        m_lfsr = 16'h1234;
        run(8, -1, 0, -1, -1, -1, -1, 0);
        exp_q = sav_q;
        n_chk++; if (stream_diff() != 0) $display("FAIL seed_rerun got %0d diffs want 0", stream_diff()); else n_pass++;
        gen_exp(128, 8, 8);
    endtask

    task automatic test_clamp_change();
        int bad = 0;
        run(20, -1, 0, -1, -1, -1, -1, 0);
        gen_exp(128, 20, 20);
        for (int b = 0; b < 8; b++) if (blk_sum(b) != 16) bad++;
        n_chk++; if (bad != 0) $display("FAIL clamp_blocks got %0d bad blocks want 0", bad); else n_pass++;
        run(3, 5, 12, -1, -1, -1, -1, 0);
        gen_exp(128, 3, 12);
        n_chk++; if (blk_sum(0) != 3) $display("FAIL chg_blk0 got %0d want 3", blk_sum(0)); else n_pass++;
        n_chk++; if (blk_sum(1) != 12) $display("FAIL chg_blk1 got %0d want 12", blk_sum(1)); else n_pass++;
        n_chk++; if (stream_diff() != 0) $display("FAIL chg_stream got %0d diffs want 0", stream_diff()); else n_pass++;
    endtask

    task automatic test_abort();
        run(8, -1, 0, 40, -1, -1, -1, 0);
        gen_exp(41, 8, 8);
        n_chk++; if (got_q.size() != 41) $display("FAIL abort_nbits got %0d want 41", got_q.size()); else n_pass++;
        n_chk++; if (done_cnt != 0) $display("FAIL abort_done got %0d want 0", done_cnt); else n_pass++;
        n_chk++; if (busy !== 0) $display("FAIL abort_busy got %0b want 0", busy); else n_pass++;
        n_chk++; if (stream_diff() != 0) $display("FAIL abort_stream got %0d diffs want 0", stream_diff()); else n_pass++;
        run(8, -1, 0, -1, -1, -1, -1, 0);
        gen_exp(128, 8, 8);
        n_chk++; if (got_q.size() != 128 || done_cnt != 1)
            $display("FAIL abort_rerun got %0d bits %0d done want 128 bits 1 done", got_q.size(), done_cnt); else n_pass++;
        n_chk++; if (stream_diff() != 0) $display("FAIL abort_rerun_stream got %0d diffs want 0", stream_diff()); else n_pass++;
    endtask

    task automatic test_midrun_reset();
        run(8, -1, 0, -1, 70, -1, -1, 0);
        gen_exp(71, 8, 8);
        n_chk++; if (got_q.size() != 71) $display("FAIL rst_nbits got %0d want 71", got_q.size()); else n_pass++;
        n_chk++; if (done_cnt != 0) $display("FAIL rst_done got %0d want 0", done_cnt); else n_pass++;
        m_lfsr = 16'hACE1;
        run(8, -1, 0, -1, -1, -1, -1, 0);
        gen_exp(128, 8, 8);
        n_chk++; if (stream_diff() != 0) $display("FAIL rst_lfsr_stream got %0d diffs want 0", stream_diff()); else n_pass++;
        load_seed(16'h0000);
        m_lfsr = 16'hACE1;
        run(8, -1, 0, -1, -1, -1, -1, 0);
        gen_exp(128, 8, 8);
        n_chk++; if (stream_diff() != 0) $display("FAIL zero_seed_stream got %0d diffs want 0", stream_diff()); else n_pass++;
    endtask

    task automatic test_ignored_inputs();
        run(8, -1, 0, -1, -1, 30, 50, 0);
        gen_exp(128, 8, 8);
        n_chk++; if (got_q.size() != 128 || done_cnt != 1)
            $display("FAIL ignore_run got %0d bits %0d done want 128 bits 1 done", got_q.size(), done_cnt); else n_pass++;
        n_chk++; if (stream_diff() != 0) $display("FAIL ignore_stream got %0d diffs want 0", stream_diff()); else n_pass++;
        run(8, -1, 0, -1, -1, -1, -1, 1);
        gen_exp(128, 8, 8);
        n_chk++; if (stream_diff() != 0) $display("FAIL start_prio_stream got %0d diffs want 0", stream_diff()); else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] s;
        logic [4:0] k;
        int bad;
        for (int r = 0; r < 4; r++) begin
            s = 16'($urandom);
            k = 5'($urandom_range(0, 20));
            load_seed(s);
            m_lfsr = (s == 0) ? 16'hACE1 : s;
            run(k, -1, 0, -1, -1, -1, -1, 0);
            gen_exp(128, k, k);
            bad = 0;
            for (int b = 0; b < 8; b++) if (blk_sum(b) != clampk(k)) bad++;
            n_chk++; if (bad != 0) $display("FAIL rand_sums run %0d k %0d got %0d bad blocks want 0", r, k, bad); else n_pass++;
            n_chk++; if (stream_diff() != 0) $display("FAIL rand_stream run %0d got %0d diffs want 0", r, stream_diff()); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_ones();
        test_all_ones();
        test_seed_repeat();
        test_clamp_change();
        test_abort();
        test_midrun_reset();
        test_ignored_inputs();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/nist_block_gen.md
NIST_BLOCK_GEN -- requirements
Module: nist_block_gen

Interface
REQ-001 SHALL have parameter N_BLK, default 8, meaning the number of 16-bit blocks emitted per run (legal range 1..255).
REQ-002 SHALL have parameter RST_SEED, default 16'hACE1, meaning the LFSR reset value and the substitute for a zero seed.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: run request, accepted only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminate the run, effective in RUN.
REQ-007 SHALL have port ones_k, input, 5 bits: target count of ones per 16-bit block.
REQ-008 SHALL have port seed_load, input, 1 bit: load seed into the LFSR, effective in IDLE only.
REQ-009 SHALL have port seed, input, 16 bits: LFSR seed value.
REQ-010 SHALL have port rnd_out, output, 1 bit: serial test bit.
REQ-011 SHALL have port bit_valid, output, 1 bit: rnd_out is valid this cycle.
REQ-012 SHALL have port blk_first, output, 1 bit: the current bit is bit 0 of a block.
REQ-013 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at normal run completion.

Function
REQ-015 SHALL implement a 2-state FSM, IDLE and RUN; a start in IDLE moves to RUN on the next edge.
REQ-016 SHALL, in RUN, emit one bit per cycle with bit_valid=1; the first bit appears in the cycle after start is sampled.
REQ-017 SHALL drive rnd_out=0, bit_valid=0 and blk_first=0 whenever the FSM is in IDLE.
REQ-018 SHALL latch k_lat = min(ones_k, 16) on start acceptance and on the last bit (pos=15) of every non-final block; mid-block changes to ones_k SHALL be ignored.
REQ-019 SHALL track pos (0..15), rem_ones and blk_cnt (8 bits); pos SHALL wrap 15->0, and on wrap SHALL reload rem_ones from k_lat and increment blk_cnt.
REQ-020 SHALL emit each bit by this rule: rem_ones==0 gives 0; rem_ones==16-pos gives 1 (forced); otherwise rnd_out = lfsr[0]. rem_ones SHALL decrement on every emitted 1.
REQ-021 SHALL guarantee that every block contains exactly k_lat ones.
REQ-022 SHALL use a 16-bit Fibonacci LFSR with taps 16,14,13,11 that shifts once per RUN cycle and holds in IDLE.
REQ-023 SHALL, on seed_load in IDLE, load seed into the LFSR on the next edge, substituting RST_SEED when seed==0; seed_load in RUN SHALL be ignored.
REQ-024 SHALL let start take priority over seed_load when both are asserted in IDLE; the seed SHALL not be loaded in that case.
REQ-025 SHALL return to IDLE after the bit with pos=15 and blk_cnt=N_BLK-1, and pulse done for exactly 1 cycle in the following cycle.
REQ-026 SHALL treat start during RUN as ignored, with no restart.
REQ-027 SHALL, on abort in RUN, finish the current bit and return to IDLE next edge with no done pulse; abort SHALL override normal completion on the same cycle.
REQ-028 SHALL hold blk_first = bit_valid & (pos==0).
REQ-029 SHALL produce exactly 16*N_BLK valid bits per completed run, with no gaps between blocks.

Reset
REQ-030 SHALL, while rstn=0 at a clock edge, enter IDLE and clear pos, rem_ones, blk_cnt and k_lat to 0, set the LFSR to RST_SEED, and drive busy=0 and done=0.
REQ-031 SHALL apply reset asserted mid-run at the next edge, with no done pulse and no further valid bits.

Verification
REQ-032 SHALL cover: ones_k=0 with start, N_BLK=8 -> 128 valid bits, all 0, blk_first high 8 times, done pulses once 129 cycles after start.
REQ-033 SHALL cover: ones_k=16 -> 128 valid bits, all 1, busy high for 128 cycles.
REQ-034 SHALL cover: ones_k=8 with seed 16'h1234 -> every block sums to 8, and a rerun with the same seed gives an identical bitstream.
REQ-035 SHALL cover: ones_k=20 -> clamped so every block has 16 ones; ones_k changed from 3 to 12 at pos=5 -> current block has 3 ones, next block has 12.
REQ-036 SHALL cover: abort at bit 40 -> bit_valid=0 from bit 41, no done, busy=0; a subsequent start gives a full 128-bit run.
REQ-037 SHALL cover: rstn=0 at bit 70 -> IDLE next edge, LFSR=RST_SEED; seed_load with seed=0 -> LFSR=RST_SEED.
